// File: rtl/swerv_nbload_ctl_pkg.sv
// Shared types for the non-blocking load controller.
// Holds the per-entry state encoding, the CAM entry payload, default sizing
// and the WAW match helper used for both the next-state and RF-write paths.
package swerv_nbload_ctl_pkg;

  localparam int NB_DEPTH = 4;
  localparam int NB_TAG_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PEND = 2'b01,
    WRB  = 2'b10
  } nbload_state_e;

  // Destination payload of one outstanding load.
  typedef struct packed {
    logic       wb;
    logic [4:0] rd;
  } load_cam_pkt_t;

  // True when a younger writer (new load or committing instruction) targets
  // the same architectural register, so the older load must not write back.
  function automatic logic waw_match(input logic [4:0] rd,
                                     input logic       clr_a,
                                     input logic [4:0] rd_a,
                                     input logic       clr_b,
                                     input logic [4:0] rd_b);
    return (clr_a && (rd == rd_a)) || (clr_b && (rd == rd_b));
  endfunction

endpackage

// File: rtl/swerv_nbload_ctl_if.sv
// Bundle of the decode/commit/LSU-facing signals of the non-blocking load
// controller.
//   master : decode, commit and LSU side (drives requests, sees results)
//   slave  : the controller itself
// Signals: alloc_*, dest_*, kill_*, wb_*, cam_rs*, rs*_hit, rf_w*, busy,
// proto_err.
interface swerv_nbload_ctl_if #(
  parameter int TAG_W = swerv_nbload_ctl_pkg::NB_TAG_W
);
  logic             alloc_valid;
  logic [4:0]       alloc_rd;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic             dest_valid;
  logic [4:0]       dest_rd;
  logic             kill_valid;
  logic [TAG_W-1:0] kill_tag;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [4:0]       cam_rs1;
  logic [4:0]       cam_rs2;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             rf_wen;
  logic [4:0]       rf_waddr;
  logic [TAG_W-1:0] rf_wtag;
  logic             busy;
  logic             proto_err;

  modport master (
    output alloc_valid, alloc_rd, dest_valid, dest_rd, kill_valid, kill_tag,
           wb_valid, wb_tag, cam_rs1, cam_rs2,
    input  alloc_ready, alloc_tag, rs1_hit, rs2_hit, rf_wen, rf_waddr,
           rf_wtag, busy, proto_err
  );

  modport slave (
    input  alloc_valid, alloc_rd, dest_valid, dest_rd, kill_valid, kill_tag,
           wb_valid, wb_tag, cam_rs1, cam_rs2,
    output alloc_ready, alloc_tag, rs1_hit, rs2_hit, rf_wen, rf_waddr,
           rf_wtag, busy, proto_err
  );

endinterface

// File: rtl/swerv_nbload_ffs.sv
// Lowest-set-bit priority encoder.
//   req_i   : request vector, bit 0 has highest priority
//   idx_o   : index of the lowest set bit (0 when none set)
//   found_o : at least one bit is set
module swerv_nbload_ffs #(
  parameter int DEPTH = swerv_nbload_ctl_pkg::NB_DEPTH,
  parameter int TAG_W = swerv_nbload_ctl_pkg::NB_TAG_W
) (
  input  logic [DEPTH-1:0] req_i,
  output logic [TAG_W-1:0] idx_o,
  output logic             found_o
);

  // Scan upward and latch the first set bit.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (req_i[i] && !found_o) begin
        idx_o   = TAG_W'(i);
        found_o = 1'b1;
      end else begin
        idx_o   = idx_o;
      end
    end
  end

endmodule

// File: rtl/swerv_nbload_ctl.sv
// Non-blocking load controller: allocates load tags, keeps a per-tag
// destination CAM, reports RAW hazards to decode and sequences the delayed
// integer-RF write when load data returns.
//   clk, rst : core clock, synchronous active-high reset
//   bus      : slave side of swerv_nbload_ctl_if (alloc, dest, kill, wb,
//              CAM lookup, RF write, busy, proto_err)
module swerv_nbload_ctl
  import swerv_nbload_ctl_pkg::*;
#(
  parameter int DEPTH = NB_DEPTH,
  parameter int TAG_W = NB_TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  swerv_nbload_ctl_if.slave  bus
);

  nbload_state_e    state_q [DEPTH];
  nbload_state_e    state_d [DEPTH];
  load_cam_pkt_t    pkt_q   [DEPTH];
  load_cam_pkt_t    pkt_d   [DEPTH];
  logic             wrb_vld_q, wrb_vld_d;
  logic [TAG_W-1:0] wrb_tag_q, wrb_tag_d;
  logic             proto_err_q, proto_err_d;

  logic [DEPTH-1:0] idle_s;
  logic [TAG_W-1:0] free_tag_s;
  logic             free_found_s;
  logic             alloc_fire_s;
  logic             alloc_clr_s;
  logic             dest_clr_s;
  load_cam_pkt_t    wrb_pkt_s;

  // Vector of free entries; WRB entries are deliberately not free.
  always_comb begin
    idle_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idle_s[i] = (state_q[i] == IDLE);
    end
  end

  swerv_nbload_ffs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_ffs (
    .req_i   (idle_s),
    .idx_o   (free_tag_s),
    .found_o (free_found_s)
  );

  assign alloc_fire_s    = bus.alloc_valid & free_found_s;
  assign alloc_clr_s     = alloc_fire_s & (bus.alloc_rd != 5'd0);
  assign dest_clr_s      = bus.dest_valid & (bus.dest_rd != 5'd0);
  assign bus.alloc_ready = free_found_s;
  assign bus.alloc_tag   = free_tag_s;
  assign bus.busy        = ~(&idle_s);
  assign bus.proto_err   = proto_err_q;
  assign wrb_pkt_s       = pkt_q[wrb_tag_q];

  // Per-entry next-state: allocate, absorb return, apply kill/WAW clears.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      state_d[i] = state_q[i];
      pkt_d[i]   = pkt_q[i];
      case (state_q[i])
        IDLE: begin
          if (alloc_fire_s && (free_tag_s == TAG_W'(i))) begin
            state_d[i]  = PEND;
            pkt_d[i].rd = bus.alloc_rd;
            pkt_d[i].wb = (bus.alloc_rd != 5'd0);
          end else begin
            state_d[i] = IDLE;
          end
        end
        PEND: begin
          if (bus.wb_valid && (bus.wb_tag == TAG_W'(i))) begin
            state_d[i] = WRB;
          end else begin
            state_d[i] = PEND;
          end
          // A killed load stays PEND so its bus return is still absorbed.
          if ((bus.kill_valid && (bus.kill_tag == TAG_W'(i))) ||
              waw_match(pkt_q[i].rd, alloc_clr_s, bus.alloc_rd,
                        dest_clr_s, bus.dest_rd)) begin
            pkt_d[i].wb = 1'b0;
          end else begin
            pkt_d[i].wb = pkt_q[i].wb;
          end
        end
        WRB: begin
          state_d[i]  = IDLE;
          pkt_d[i].wb = 1'b0;
        end
        default: begin
          state_d[i] = IDLE;
          pkt_d[i]   = '0;
        end
      endcase
    end
  end

  // Writeback slot and protocol checks are registered straight from wb_tag.
  always_comb begin
    wrb_vld_d   = bus.wb_valid && (state_q[bus.wb_tag] == PEND);
    wrb_tag_d   = bus.wb_tag;
    proto_err_d = (bus.wb_valid && (state_q[bus.wb_tag] != PEND)) ||
                  (bus.kill_valid && (state_q[bus.kill_tag] == IDLE));
  end

  // RF write from the WRB entry; a same-cycle WAW clear still suppresses it.
  always_comb begin
    if (wrb_vld_q) begin
      bus.rf_wen   = wrb_pkt_s.wb &
                     ~waw_match(wrb_pkt_s.rd, alloc_clr_s, bus.alloc_rd,
                                dest_clr_s, bus.dest_rd);
      bus.rf_waddr = wrb_pkt_s.rd;
      bus.rf_wtag  = wrb_tag_q;
    end else begin
      bus.rf_wen   = 1'b0;
      bus.rf_waddr = 5'd0;
      bus.rf_wtag  = '0;
    end
  end

  // RAW hazard lookup against pending and writing-back loads.
  always_comb begin
    bus.rs1_hit = 1'b0;
    bus.rs2_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((state_q[i] != IDLE) && pkt_q[i].wb) begin
        bus.rs1_hit = bus.rs1_hit |
                      ((bus.cam_rs1 != 5'd0) && (pkt_q[i].rd == bus.cam_rs1));
        bus.rs2_hit = bus.rs2_hit |
                      ((bus.cam_rs2 != 5'd0) && (pkt_q[i].rd == bus.cam_rs2));
      end else begin
        bus.rs1_hit = bus.rs1_hit;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= IDLE;
        pkt_q[i]   <= '0;
      end
      wrb_vld_q   <= 1'b0;
      wrb_tag_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= state_d[i];
        pkt_q[i]   <= pkt_d[i];
      end
      wrb_vld_q   <= wrb_vld_d;
      wrb_tag_q   <= wrb_tag_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: doc/swerv_nbload_ctl.md
Name: swerv_nbload_ctl

Overview:
- Tracks outstanding non-blocking loads between LSU issue and register-file writeback.
- Allocates load tags and holds a per-tag destination CAM (valid/wb/tag/rd).
- Reports RAW hazards to decode and sequences the delayed integer-RF write when load data returns.
- Sits between the decode/commit logic and the LSU bus-return path.

Parameters:
- DEPTH, 4, number of outstanding non-blocking loads; power of 2, range 2..8.
- TAG_W, 2, tag width; must equal log2(DEPTH).

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, synchronous, active-high.
- alloc_valid  in  1  a new non-blocking load requests a tag.
- alloc_rd  in  5  destination register of the new load.
- alloc_ready  out  1  a free entry exists.
- alloc_tag  out  TAG_W  tag granted; valid when alloc_valid & alloc_ready.
- dest_valid  in  1  an older, non-load instruction commits a write to dest_rd.
- dest_rd  in  5  its destination register.
- kill_valid  in  1  the load holding kill_tag is flushed; its result must not be written.
- kill_tag  in  TAG_W  tag to kill.
- wb_valid  in  1  load data returned for wb_tag.
- wb_tag  in  TAG_W  returning tag.
- cam_rs1  in  5  decode source operand 1.
- cam_rs2  in  5  decode source operand 2.
- rs1_hit  out  1  rs1 depends on a pending load.
- rs2_hit  out  1  rs2 depends on a pending load.
- rf_wen  out  1  RF write enable for returned load data.
- rf_waddr  out  5  RF write address.
- rf_wtag  out  TAG_W  tag being written, used by the LSU to steer its data mux.
- busy  out  1  any entry not IDLE.
- proto_err  out  1  one-cycle pulse on wb_valid or kill_valid to an IDLE tag.

Behaviour:
- Each entry has state IDLE, PEND or WRB, plus fields wb and rd (load_cam_pkt_t).
- Reset: all entries IDLE, wb=0, rd=0. Outputs at reset: alloc_ready=1, alloc_tag=0, all hits 0, rf_wen=0, rf_waddr=0, rf_wtag=0, busy=0, proto_err=0.
- alloc_ready is 1 iff some entry is IDLE in the current state.
- alloc_tag is the lowest-index IDLE entry.
- Allocation:
  - On alloc_valid & alloc_ready, the entry goes IDLE→PEND next cycle with rd=alloc_rd and wb=(alloc_rd!=0).
  - alloc_valid while not ready is ignored; the requester holds.
- WAW clearing:
  - alloc_valid & alloc_ready with alloc_rd!=0 clears wb on every other PEND/WRB entry whose rd equals alloc_rd.
  - dest_valid with dest_rd!=0 does the same, but only for entries already non-IDLE this cycle, never the one being allocated.
- Kill: kill_valid clears wb of kill_tag next cycle. The entry stays PEND so the bus return is still absorbed.
- Return: wb_valid on a PEND entry moves it PEND→WRB.
- WRB→IDLE always after exactly one cycle. In that WRB cycle: rf_wen=wb, rf_waddr=rd, rf_wtag=tag.
- rf_wen/rf_waddr/rf_wtag are driven from registered state, so latency is wb_valid to rf_wen = 1 cycle.
- At most one entry is in WRB per cycle, because wb_valid is single-ported.
- kill and wb on the same tag in the same cycle: kill wins, entry goes to WRB with wb=0, no RF write.
- dest/alloc WAW clearing on an entry in WRB this cycle suppresses its rf_wen (the clear is applied combinationally to rf_wen).
- Hits: rsN_hit=1 iff cam_rsN!=0 and some PEND or WRB entry has wb=1 and rd=cam_rsN. The same-cycle wb/kill/clear updates are not reflected until the next cycle.
- A WRB entry is not allocatable. A tag freed this cycle is allocatable next cycle, which prevents tag reuse before the RF write.
- proto_err:
  - wb_valid on an IDLE or WRB tag: pulses for one cycle; state unchanged.
  - kill_valid on an IDLE tag: pulses for one cycle; state unchanged.
- busy = OR over entries of (state != IDLE).
- Reset asserted mid-operation: all entries go IDLE next edge; a pending rf_wen is dropped.

Decomposition:
- Add to the shared types package:
  - nbload_state_e enum {IDLE=2'b00, PEND=2'b01, WRB=2'b10}.
  - Reuse load_cam_pkt_t for the entry fields.
- Sub-module swerv_nbload_ffs: lowest-set-bit priority encoder, DEPTH in, TAG_W out plus a found flag. Used for alloc_tag.
- WRB selection needs no encoder; it is registered directly from wb_tag.

Test Plan:
- Reset, then alloc rd=5: alloc_tag=0; next cycle busy=1 and cam_rs1=5 gives rs1_hit=1. Then wb_valid tag0: one cycle later rf_wen=1, rf_waddr=5; the cycle after, busy=0 and rs1_hit=0.
- Fill all 4 entries (rd=1..4): tags 0,1,2,3 and then alloc_ready=0. wb tag2 followed by alloc rd=9 the following cycle: the new alloc gets tag2 only once the entry is IDLE (2 cycles after wb_valid).
- alloc rd=7 (tag0), then dest_valid rd=7: rs1_hit for 7 drops to 0; wb tag0 gives rf_wen=0.
- alloc rd=8 (tag0), then alloc rd=8 (tag1): tag0 wb cleared; wb tag0 gives no write; wb tag1 gives rf_wen=1, rf_waddr=8.
- kill_valid and wb_valid on tag1 in the same cycle: no rf_wen, tag1 IDLE 2 cycles later. wb_valid on an IDLE tag3: proto_err pulses for 1 cycle, state unchanged.
- alloc rd=0: tag granted, rs hits never assert, rf_wen=0 on return. rst asserted while an entry is in WRB: rf_wen=0 next cycle, alloc_ready=1.
